count_seq_arb: RTL and testbench
================================

# count_seq_arb

Sequencer and round-robin arbiter that owns the control inputs of the 4-bit loadable up/down counter (data_in, load, up_down) and shares it between two requesters. Each requester submits a (start, target, direction) command. The block loads the counter with start, lets it count in the requested direction until count equals target, then parks it at target and pulses a per-requester done. It sits between the requesting logic and the counter and replaces direct driving of the counter's control pins.

## Interface
- WIDTH, 4, counter data width; count wraps modulo 2^WIDTH.
- clock  in  1  sole clock; all state changes on posedge.
- resetn  in  1  asynchronous, active-low reset; the counter shares this reset.
- req_valid  in  2  per-requester command valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; a command transfers on valid&&ready at posedge.
- req_start0 / req_start1  in  WIDTH  start value of requester 0 / 1.
- req_target0 / req_target1  in  WIDTH  target value of requester 0 / 1.
- req_dir  in  2  per-requester direction; 1 = up, 0 = down.
- done  out  2  one-cycle pulse on bit i when requester i's command completes.
- busy  out  1  high in LOAD and RUN states.
- count  in  WIDTH  counter output, registered by the counter.
- data_in  out  WIDTH  counter load value.
- load  out  1  counter synchronous load.
- up_down  out  1  counter direction; 1 = up.

## Operation
- Counter model: at each posedge, if load, then count <= data_in. Otherwise count <= count±1 mod 2^WIDTH. The counter has no enable, so holding a value always requires load=1.
- Registered state: fsm (IDLE, LOAD, RUN), cmd_start, cmd_target, cmd_dir, cmd_id, hold_val, rr_ptr, done.
- IDLE:
  - Drives load=1, data_in=hold_val, up_down=1, so the counter is parked.
  - Arbitration: if exactly one req_valid bit is set, grant it. If both are set, grant the requester other than the last one served, selected by rr_ptr.
  - req_ready[g]=1 only for the granted requester. The ready output is combinational from fsm, rr_ptr and req_valid.
  - On transfer: latch start, target, dir and id; set rr_ptr to the served id; go to LOAD.
- LOAD (exactly 1 cycle): drives load=1, data_in=cmd_start, up_down=cmd_dir. Goes to RUN.
- RUN:
  - Drives up_down=cmd_dir and data_in=cmd_target.
  - load=(count==cmd_target), combinational, so the counter freezes on target at the same edge it is detected.
  - When count==cmd_target: set hold_val=cmd_target, done[cmd_id]<=1 for one cycle, go to IDLE.
- Direction is honoured literally, with wrap-around. Distance d = (target−start) mod 2^WIDTH for up, and (start−target) mod 2^WIDTH for down.
- start==target gives d=0. Completion is detected in the first RUN cycle.
- req_ready is 0 outside IDLE. Commands presented while busy wait; they are not dropped.
- Reset, asynchronous and valid at any time including mid-RUN:
  - fsm=IDLE, hold_val=0, rr_ptr=1, so requester 0 wins the first tie.
  - done=0, busy=0.
  - Outputs go to load=1, data_in=0, up_down=1 and req_ready=0 until a valid arrives.
  - An in-flight command is discarded with no done.

## Timing
- The command is accepted at edge E0. LOAD occupies cycle E0..E1. count==start from E1.
- RUN lasts d+1 cycles. done is high for exactly the one cycle after edge E(d+2), and fsm is IDLE in that cycle.
- Latency from acceptance to done is d+2 cycles. The next command can be accepted at the edge ending the done cycle, so back-to-back throughput is d+3 cycles per command.
- count is never observed past target. The counter holds target from the completion edge until the next LOAD.
- busy=1 from E0 through the final RUN cycle.

## Test plan
- Reset then idle: resetn low mid-cycle -> immediately load=1, data_in=0, done=0, req_ready=0. After release with no valid, count stays 0 indefinitely.
- Single up command: requester 0 sends start=3, target=7, dir=1 -> count 3,4,5,6,7, then holds at 7. done[0] pulses 6 cycles after acceptance, busy is high for 6 cycles.
- Wrap-around down: requester 1 sends start=2, target=14, dir=0 -> count 2,1,0,15,14. done[1] pulses after 6 cycles and count holds at 14.
- Zero distance: start=target=9 -> one LOAD cycle, one RUN cycle, done 2 cycles after acceptance, count=9.
- Contention: both requesters valid continuously from reset -> grants alternate 0,1,0,1, and each done bit matches its requester's id. A request held during busy is accepted on the first IDLE cycle.
- Reset mid-RUN: start=0, target=15, dir=1; assert resetn at count=5 -> no done, count=0, fsm IDLE. A new command afterwards completes normally.

Source files
------------

// File: rtl/count_seq_arb.sv
// count_seq_arb: round-robin sequencer that owns the load/data/direction pins of a shared up/down counter
module count_seq_arb #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_start0,
  input  logic [WIDTH-1:0] req_start1,
  input  logic [WIDTH-1:0] req_target0,
  input  logic [WIDTH-1:0] req_target1,
  input  logic [1:0]       req_dir,
  output logic [1:0]       done,
  output logic             busy,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] data_in,
  output logic             load,
  output logic             up_down
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d, target_q, target_d, hold_q, hold_d;
  logic dir_q, dir_d, id_q, id_d, rr_q, rr_d;
  logic [1:0] done_q, done_d, gnt;
  assign gnt = &req_valid ? (rr_q ? 2'b01 : 2'b10) : req_valid;
  assign req_ready = (state_q == IDLE) ? gnt : 2'b00;
  assign busy = state_q != IDLE;
  assign done = done_q;
  // next state and counter control; the counter has no enable, so idle parks it by reloading hold_q
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    target_d = target_q;
    hold_d = hold_q;
    dir_d = dir_q;
    id_d = id_q;
    rr_d = rr_q;
    done_d = 2'b00;
    load = 1'b1;
    data_in = hold_q;
    up_down = 1'b1;
    unique case (state_q)
      IDLE: if (|gnt) begin
        start_d = gnt[1] ? req_start1 : req_start0;
        target_d = gnt[1] ? req_target1 : req_target0;
        dir_d = gnt[1] ? req_dir[1] : req_dir[0];
        id_d = gnt[1];
        rr_d = gnt[1];
        state_d = LOAD;
      end
      LOAD: begin
        data_in = start_q;
        up_down = dir_q;
        state_d = RUN;
      end
      RUN: begin
        data_in = target_q;
        up_down = dir_q;
        load = count == target_q;
        if (count == target_q) begin
          hold_d = target_q;
          done_d = id_q ? 2'b10 : 2'b01;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset discards any in-flight command and gives requester 0 the first tie
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      start_q <= '0;
      target_q <= '0;
      hold_q <= '0;
      dir_q <= 1'b1;
      id_q <= 1'b0;
      rr_q <= 1'b1;
      done_q <= 2'b00;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      target_q <= target_d;
      hold_q <= hold_d;
      dir_q <= dir_d;
      id_q <= id_d;
      rr_q <= rr_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_count_seq_arb.sv
// tb_count_seq_arb: randomized and directed checks of count_seq_arb against a transaction-level model
module tb_count_seq_arb;
  logic clock = 1'b0, resetn = 1'b0;
  logic [1:0] req_valid = 2'b00, req_ready, req_dir = 2'b00, done;
  logic [3:0] s0 = '0, s1 = '0, t0 = '0, t1 = '0, count, data_in;
  logic busy, load, up_down;
  always #5 clock = ~clock;
  count_seq_arb #(.WIDTH(4)) dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_start0(s0), .req_start1(s1), .req_target0(t0), .req_target1(t1),
    .req_dir(req_dir), .done(done), .busy(busy), .count(count),
    .data_in(data_in), .load(load), .up_down(up_down)
  );
  // environment: the 4-bit loadable up/down counter the block controls
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) count <= '0;
    else if (load) count <= data_in;
    else count <= up_down ? count + 4'd1 : count - 4'd1;
  end
  int n_tests = 0, n_fail = 0, busy_cnt = 0;
  bit m_act = 0, m_dir = 0, m_id = 0, m_last = 1, refill = 0, rnd = 0, alt_chk = 0;
  int m_k = 0, m_d = 0;
  logic [3:0] m_s = '0, m_t = '0, m_hold = '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic new_cmd(input int i, input logic [3:0] s, input logic [3:0] t, input bit dir);
    if (i == 0) begin s0 = s; t0 = t; end else begin s1 = s; t1 = t; end
    req_dir[i] = dir;
    req_valid[i] = 1'b1;
  endtask
  task automatic rnd_cmd(input int i);
    new_cmd(i, 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
  endtask
  function automatic logic [1:0] exp_grant(input logic [1:0] v);
    if (v == 2'b01 || v == 2'b10 || v == 2'b00) return v;
    return m_last ? 2'b01 : 2'b10;
  endfunction
  // one clock cycle: check outputs at negedge, check ready, advance model at posedge, update drives
  task automatic cyc();
    logic [1:0] acc, er;
    logic [3:0] ec;
    bit running;
    bit g;
    g = 0;
    running = m_act && m_k <= m_d + 1;
    if (busy === 1'b1) busy_cnt++;
    if (running) begin
      chk("busy", busy, 1);
      chk("done_busy", done, 0);
      chk("up_down", up_down, m_dir);
      if (m_k == 0) begin
        chk("load_ld", load, 1);
        chk("data_ld", data_in, m_s);
        chk("count_ld", count, m_hold);
      end else begin
        ec = m_dir ? m_s + 4'(m_k - 1) : m_s - 4'(m_k - 1);
        chk("count_run", count, ec);
        chk("data_run", data_in, m_t);
        chk("load_run", load, (m_k - 1 == m_d) ? 1 : 0);
      end
    end else begin
      chk("busy_idle", busy, 0);
      chk("load_idle", load, 1);
      chk("data_idle", data_in, m_hold);
      chk("updn_idle", up_down, 1);
      chk("count_idle", count, m_hold);
      chk("done", done, (m_act && m_k == m_d + 2) ? (m_id ? 2 : 1) : 0);
    end
    #1;
    er = running ? 2'b00 : exp_grant(req_valid);
    chk("ready", req_ready, er);
    acc = req_valid & er;
    @(posedge clock);
    if (acc != 2'b00) begin
      g = acc[1];
      if (alt_chk) chk("alternate", g, !m_last);
      m_act = 1; m_k = 0; m_id = g; m_last = g;
      m_s = g ? s1 : s0;
      m_t = g ? t1 : t0;
      m_dir = req_dir[g];
      m_d = m_dir ? int'(4'(m_t - m_s)) : int'(4'(m_s - m_t));
    end else if (m_act) begin
      if (m_k == m_d + 2) m_act = 0;
      else begin
        m_k++;
        if (m_k == m_d + 2) m_hold = m_t;
      end
    end
    @(negedge clock);
    if (acc != 2'b00) begin
      if (refill) rnd_cmd(int'(g));
      else req_valid[g] = 1'b0;
    end
    if (rnd) for (int i = 0; i < 2; i++) if (!req_valid[i] && $urandom_range(3) == 0) rnd_cmd(i);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  // asynchronous reset asserted mid-cycle; outputs must react before any clock edge
  task automatic do_reset();
    #2;
    req_valid = 2'b00;
    resetn = 1'b0;
    #1;
    chk("rst_load", load, 1);
    chk("rst_data", data_in, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    m_act = 0; m_last = 1; m_hold = '0;
    @(negedge clock);
    #2 resetn = 1'b1;
    @(negedge clock);
  endtask
  initial begin
    @(negedge clock);
    do_reset();
    run(6);
    busy_cnt = 0;
    new_cmd(0, 4'd3, 4'd7, 1'b1);
    run(10);
    chk("busy_len_up", busy_cnt, 6);
    chk("hold_up", count, 7);
    busy_cnt = 0;
    new_cmd(1, 4'd2, 4'd14, 1'b0);
    run(10);
    chk("busy_len_wrap", busy_cnt, 6);
    chk("hold_wrap", count, 14);
    busy_cnt = 0;
    new_cmd(0, 4'd9, 4'd9, 1'b1);
    run(5);
    chk("busy_len_zero", busy_cnt, 2);
    chk("hold_zero", count, 9);
    do_reset();
    refill = 1; alt_chk = 1;
    rnd_cmd(0);
    rnd_cmd(1);
    run(120);
    refill = 0; alt_chk = 0;
    run(50);
    chk("drained", req_valid, 0);
    new_cmd(0, 4'd0, 4'd15, 1'b1);
    for (int i = 0; i < 30 && count != 4'd5; i++) cyc();
    chk("reach5", count, 5);
    do_reset();
    run(3);
    chk("post_rst_count", count, 0);
    busy_cnt = 0;
    new_cmd(1, 4'd4, 4'd6, 1'b1);
    run(8);
    chk("busy_len_after", busy_cnt, 4);
    chk("hold_after", count, 6);
    rnd = 1;
    run(2000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
